// File: rtl/rsp_chan_mngr_pkg.sv
// Shared types and constants for the response channel manager.
// State encodings, tracker geometry and the OKAY response code.
package rsp_chan_mngr_pkg;

    localparam int TRK_DEPTH = 4;
    localparam int ID_W      = 4;
    localparam int ADDR_W    = 32;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        RSPC_IDLE = 2'b00,
        RSPC_WAIT = 2'b01,
        RSPC_HOLD = 2'b10,
        RSPC_DEFO = 2'b11
    } rspc_state_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
    } trk_entry_t;

endpackage

// File: rtl/rsp_trk_fifo.sv
// In-order outstanding-request tracker: 4-deep FIFO of {id, addr}.
// A push while full is dropped unless a pop frees a slot the same cycle.
module rsp_trk_fifo
    import rsp_chan_mngr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  trk_entry_t i_entry,
    output trk_entry_t o_head,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_ovf
);

    trk_entry_t r_mem [TRK_DEPTH];
    logic [1:0] r_wptr;
    logic [1:0] r_rptr;
    logic [2:0] r_cnt;
    logic       r_ovf;
    logic       w_pop_ok;
    logic       w_push_ok;

    assign o_full    = (r_cnt == 3'(TRK_DEPTH));
    assign o_empty   = (r_cnt == 3'd0);
    assign o_head    = r_mem[r_rptr];
    assign o_ovf     = r_ovf;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TRK_DEPTH; i++) r_mem[i] <= '0;
            r_wptr <= 2'd0;
            r_rptr <= 2'd0;
            r_cnt  <= 3'd0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= i_entry;
                r_wptr        <= r_wptr + 2'd1;
            end
            if (w_pop_ok) r_rptr <= r_rptr + 2'd1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (i_push && o_full && !w_pop_ok) r_ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/rsp_chan_mngr.sv
// Response channel manager: matches in-order read responses against the
// outstanding tracker and presents one registered result at a time.
module rsp_chan_mngr
    import rsp_chan_mngr_pkg::*;
#(
    parameter logic [1:0] RSPC_M_ID = 2'b00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_rq,
    input  logic [3:0]  in_id,
    input  logic [31:0] in_addr,
    output logic        trk_full,
    output logic        trk_empty,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [3:0]  r_id,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_id,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic        ovf_err
);

    rspc_state_t r_state;
    trk_entry_t  w_head;
    trk_entry_t  w_entry;
    logic        w_hs;
    logic        w_id_mis;

    assign w_entry  = '{id: in_id, addr: in_addr};
    assign r_ready  = (r_state == RSPC_WAIT);
    assign out_valid = (r_state == RSPC_HOLD);
    assign w_hs     = r_valid & r_ready;
    // Full 4-bit compare; the upper bits are the master ID RSPC_M_ID.
    assign w_id_mis = (r_id != w_head.id);

    rsp_trk_fifo u_trk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (in_rq),
        .i_pop   (w_hs),
        .i_entry (w_entry),
        .o_head  (w_head),
        .o_full  (trk_full),
        .o_empty (trk_empty),
        .o_ovf   (ovf_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RSPC_IDLE;
            out_id   <= '0;
            out_addr <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else begin
            if (w_hs) begin
                out_id   <= w_head.id;
                out_addr <= w_head.addr;
                out_data <= r_data;
                out_err  <= (r_resp != RESP_OKAY) | w_id_mis;
            end
            case (r_state)
                RSPC_IDLE: if (in_rq || !trk_empty) r_state <= RSPC_WAIT;
                RSPC_WAIT: if (w_hs) r_state <= RSPC_HOLD;
                // Count here is already post-pop; a same-cycle push keeps us busy.
                RSPC_HOLD: if (out_ready)
                               r_state <= (trk_empty && !in_rq) ? RSPC_IDLE : RSPC_WAIT;
                default:   r_state <= RSPC_DEFO;
            endcase
        end
    end

endmodule

// File: tb/tb_rsp_chan_mngr.sv
// Directed self-checking bench for rsp_chan_mngr.
module tb_rsp_chan_mngr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_rq = 1'b0;
    logic [3:0]  in_id = '0;
    logic [31:0] in_addr = '0;
    logic        trk_full, trk_empty;
    logic        r_valid = 1'b0;
    logic        r_ready;
    logic [3:0]  r_id = '0;
    logic [31:0] r_data = '0;
    logic [1:0]  r_resp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_id;
    logic [31:0] out_addr, out_data;
    logic        out_err, ovf_err;

    int n_chk = 0;
    int n_fail = 0;

    rsp_chan_mngr #(.RSPC_M_ID(2'b00)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_rq(in_rq), .in_id(in_id), .in_addr(in_addr),
        .trk_full(trk_full), .trk_empty(trk_empty),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_addr(out_addr), .out_data(out_data),
        .out_err(out_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; in_rq = 0; r_valid = 0; out_ready = 0; r_resp = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [3:0] id, input logic [31:0] addr);
        in_rq = 1'b1; in_id = id; in_addr = addr;
        tick();
        in_rq = 1'b0;
    endtask

    task automatic respond(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp);
        r_valid = 1'b1; r_id = id; r_data = data; r_resp = resp;
        tick();
        r_valid = 1'b0; r_resp = 2'b00;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_chk++; if ({r_ready, out_valid, out_err, ovf_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctl got %b exp 0000", {r_ready, out_valid, out_err, ovf_err}); end
        n_chk++; if ({trk_full, trk_empty} !== 2'b01) begin
            n_fail++; $display("FAIL reset_flags got %b exp 01", {trk_full, trk_empty}); end
        n_chk++; if ({out_id, out_addr, out_data} !== 68'h0) begin
            n_fail++; $display("FAIL reset_data got %h exp 0", {out_id, out_addr, out_data}); end
        apply_reset();
    endtask

    task automatic test_single();
        push(4'h1, 32'h1000);
        n_chk++; if ({r_ready, trk_empty} !== 2'b10) begin
            n_fail++; $display("FAIL single_push got %b exp 10", {r_ready, trk_empty}); end
        respond(4'h1, 32'hDEADBEEF, 2'b00);
        n_chk++; if ({out_valid, r_ready, out_err} !== 3'b100) begin
            n_fail++; $display("FAIL single_ctl got %b exp 100", {out_valid, r_ready, out_err}); end
        n_chk++; if ({out_id, out_addr, out_data} !== {4'h1, 32'h1000, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL single_data got %h exp %h", {out_id, out_addr, out_data},
                               {4'h1, 32'h1000, 32'hDEADBEEF}); end
        consume();
        n_chk++; if ({out_valid, r_ready, trk_empty} !== 3'b001) begin
            n_fail++; $display("FAIL single_done got %b exp 001", {out_valid, r_ready, trk_empty}); end
    endtask

    task automatic test_full_ovf();
        apply_reset();
        for (int i = 0; i < 4; i++) push(4'(i), 32'h4000 + 32'(i) * 32'h10);
        n_chk++; if ({trk_full, ovf_err} !== 2'b10) begin
            n_fail++; $display("FAIL full_flag got %b exp 10", {trk_full, ovf_err}); end
        push(4'hF, 32'hBAD0);
        n_chk++; if ({trk_full, ovf_err} !== 2'b11) begin
            n_fail++; $display("FAIL ovf_set got %b exp 11", {trk_full, ovf_err}); end
        for (int i = 0; i < 4; i++) begin
            respond(4'(i), 32'hA0 + 32'(i), 2'b00);
            n_chk++; if ({out_valid, out_id, out_addr, out_err} !== {1'b1, 4'(i), 32'h4000 + 32'(i) * 32'h10, 1'b0}) begin
                n_fail++; $display("FAIL full_order[%0d] got v%b id%h a%h e%b", i, out_valid, out_id, out_addr, out_err); end
            if (i == 0) begin
                n_chk++; if (trk_full !== 1'b0) begin
                    n_fail++; $display("FAIL full_clear got %b exp 0", trk_full); end
            end
            consume();
        end
        n_chk++; if ({trk_empty, ovf_err, r_ready} !== 3'b110) begin
            n_fail++; $display("FAIL full_drain got %b exp 110", {trk_empty, ovf_err, r_ready}); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] exp_a [4];
        logic [3:0]  exp_i [4];
        apply_reset();
        for (int i = 0; i < 4; i++) push(4'(i), 32'h5000 + 32'(i) * 32'h4);
        in_rq = 1'b1; in_id = 4'h0; in_addr = 32'h5100;
        respond(4'h0, 32'h11, 2'b00);
        in_rq = 1'b0;
        n_chk++; if ({trk_full, ovf_err, out_valid} !== 3'b101) begin
            n_fail++; $display("FAIL pp_flags got %b exp 101", {trk_full, ovf_err, out_valid}); end
        n_chk++; if (out_addr !== 32'h5000) begin
            n_fail++; $display("FAIL pp_first got %h exp 5000", out_addr); end
        consume();
        exp_i = '{4'h1, 4'h2, 4'h3, 4'h0};
        exp_a = '{32'h5004, 32'h5008, 32'h500C, 32'h5100};
        for (int i = 0; i < 4; i++) begin
            respond(exp_i[i], 32'h20 + 32'(i), 2'b00);
            n_chk++; if ({out_id, out_addr, out_err} !== {exp_i[i], exp_a[i], 1'b0}) begin
                n_fail++; $display("FAIL pp_order[%0d] got id%h a%h e%b exp id%h a%h", i, out_id, out_addr, out_err,
                                   exp_i[i], exp_a[i]); end
            consume();
        end
        n_chk++; if (trk_empty !== 1'b1) begin
            n_fail++; $display("FAIL pp_empty got %b exp 1", trk_empty); end
    endtask

    task automatic test_mismatch();
        apply_reset();
        push(4'h2, 32'h2000);
        push(4'h2, 32'h2200);
        respond(4'h3, 32'h33, 2'b00);
        n_chk++; if ({out_id, out_addr, out_err} !== {4'h2, 32'h2000, 1'b1}) begin
            n_fail++; $display("FAIL mis_id got id%h a%h e%b exp id2 a2000 e1", out_id, out_addr, out_err); end
        consume();
        respond(4'h2, 32'h44, 2'b10);
        n_chk++; if ({out_id, out_addr, out_data, out_err} !== {4'h2, 32'h2200, 32'h44, 1'b1}) begin
            n_fail++; $display("FAIL mis_resp got id%h a%h d%h e%b", out_id, out_addr, out_data, out_err); end
        consume();
        n_chk++; if (trk_empty !== 1'b1) begin
            n_fail++; $display("FAIL mis_empty got %b exp 1", trk_empty); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        push(4'h1, 32'h3000);
        push(4'h1, 32'h3100);
        respond(4'h1, 32'hAAAA0001, 2'b00);
        r_valid = 1'b1; r_id = 4'h1; r_data = 32'hBBBB0002;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if ({out_valid, r_ready, out_data, out_addr} !== {2'b10, 32'hAAAA0001, 32'h3000}) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v%b r%b d%h a%h", i, out_valid, r_ready, out_data, out_addr); end
        end
        consume();
        n_chk++; if ({out_valid, r_ready, out_data} !== {2'b01, 32'hAAAA0001}) begin
            n_fail++; $display("FAIL bp_release got v%b r%b d%h", out_valid, r_ready, out_data); end
        tick();
        r_valid = 1'b0;
        n_chk++; if ({out_valid, out_data, out_addr} !== {1'b1, 32'hBBBB0002, 32'h3100}) begin
            n_fail++; $display("FAIL bp_second got v%b d%h a%h", out_valid, out_data, out_addr); end
        consume();
    endtask

    task automatic test_reset_hold();
        apply_reset();
        for (int i = 0; i < 4; i++) push(4'(i), 32'h6000 + 32'(i));
        respond(4'h0, 32'h77, 2'b01);
        n_chk++; if ({out_valid, out_err, trk_empty, trk_full} !== 4'b1100) begin
            n_fail++; $display("FAIL rh_pre got %b exp 1100", {out_valid, out_err, trk_empty, trk_full}); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({out_valid, r_ready, out_err, trk_empty, trk_full, out_id, out_addr, out_data} !==
                     {5'b00010, 68'h0}) begin
            n_fail++; $display("FAIL rh_async got v%b r%b e%b em%b f%b %h", out_valid, r_ready, out_err,
                               trk_empty, trk_full, {out_id, out_addr, out_data}); end
        tick();
        rst_n = 1'b1;
        tick();
        n_chk++; if ({trk_empty, r_ready, out_valid} !== 3'b100) begin
            n_fail++; $display("FAIL rh_after got %b exp 100", {trk_empty, r_ready, out_valid}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_ovf();
        test_push_pop_full();
        test_mismatch();
        test_backpressure();
        test_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
